async_transmitter: RTL and testbench

ASYNC_TRANSMITTER -- requirements
Module: async_transmitter

---
 rtl/async_serial_pkg.sv | 8 +
 rtl/async_transmitter_if.sv | 10 +
 rtl/async_tx_shifter.sv | 29 ++
 rtl/async_transmitter.sv | 64 ++++++
 tb/tb_async_transmitter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/async_serial_pkg.sv
// async_serial_pkg: frame states, slot levels and frame length shared by the async serial transmitter and receiver
package async_serial_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic START_LEVEL = 1'b0;
  function automatic int frame_len(input int data_bits);
    return data_bits + 3;
  endfunction
endpackage

// File: rtl/async_transmitter_if.sv
// async_transmitter_if: word handshake (Valid/Din/Ready) plus serial line Q and Busy; master drives words, slave transmits
interface async_transmitter_if #(parameter int DATA_BITS = 5);
  logic Valid;
  logic [DATA_BITS-1:0] Din;
  logic Ready;
  logic Q;
  logic Busy;
  modport master(output Valid, Din, input Ready, Q, Busy);
  modport slave(input Valid, Din, output Ready, Q, Busy);
endinterface

// File: rtl/async_tx_shifter.sv
// async_tx_shifter: LSB-first shift register with running odd-parity accumulator (load, shift, data_in -> bit_out, parity_out)
module async_tx_shifter #(
  parameter int DATA_BITS = 5
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 load,
  input  logic                 shift,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 bit_out,
  output logic                 parity_out
);
  logic [DATA_BITS-1:0] sr;
  logic par;
  assign bit_out = sr[0];
  assign parity_out = par;
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      sr <= '0;
      par <= 1'b0;
    end else if (load) begin
      sr <= data_in;
      par <= 1'b1;
    end else if (shift) begin
      sr <= sr >> 1;
      par <= par ^ sr[0];
    end
  end
endmodule

// File: rtl/async_transmitter.sv
// async_transmitter: one-entry buffered serial framer (start, LSB-first data, odd parity, stop) on bus.Q with Busy/Ready
module async_transmitter
  import async_serial_pkg::*;
#(
  parameter int   DATA_BITS  = 5,
  parameter logic STOP_LEVEL = 1'b0,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input logic Clk,
  input logic Rst_n,
  async_transmitter_if.slave bus
);
  localparam int CW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  state_t state, nxt;
  logic full, accept, load, last, slot, bit_out, parity_out;
  logic [DATA_BITS-1:0] hold;
  logic [CW-1:0] cnt;
  assign accept = bus.Valid & ~full;
  assign load = nxt == START;
  assign last = cnt == CW'(DATA_BITS - 1);
  assign bus.Ready = ~full;
  assign bus.Busy = state != IDLE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = full ? START : IDLE;
      START:   nxt = DATA;
      DATA:    nxt = last ? PARITY : DATA;
      PARITY:  nxt = STOP;
      STOP:    nxt = full ? START : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    slot = state == START  ? START_LEVEL :
           state == DATA   ? bit_out :
           state == PARITY ? parity_out :
           state == STOP   ? STOP_LEVEL : IDLE_LEVEL;
  end
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= IDLE;
      full <= 1'b0;
      hold <= '0;
      cnt <= '0;
      bus.Q <= IDLE_LEVEL;
    end else begin
      state <= nxt;
      full <= accept | (full & ~load);
      if (accept) hold <= bus.Din;
      cnt <= (state == DATA && !last) ? cnt + 1'b1 : '0;
      bus.Q <= slot;
    end
  end
  async_tx_shifter #(.DATA_BITS(DATA_BITS)) u_shifter (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .load      (load),
    .shift     (state == DATA),
    .data_in   (hold),
    .bit_out   (bit_out),
    .parity_out(parity_out)
  );
endmodule

// File: tb/tb_async_transmitter.sv
// tb_async_transmitter: scoreboard bench with a behavioural receiver decoding Q back into words
module tb_async_transmitter;
  import async_serial_pkg::*;
  localparam int DB = 5;
  localparam int FL = frame_len(DB);
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [DB-1:0] exp_q[$];
  logic [DB:0] rx_q[$];
  int pos = -1;
  logic [DB-1:0] rd;
  logic rpar;
  async_transmitter_if #(.DATA_BITS(DB)) bus();
  async_transmitter dut(.Clk(clk), .Rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [FL-1:0] frame(input logic [DB-1:0] d);
    return {1'b0, ~^d, d, 1'b0};
  endfunction
  always @(posedge clk) begin
    #2;
    if (!rst_n) pos = -1;
    else if (pos < 0) begin
      if (bus.Q == 1'b0) pos = 0;
    end else begin
      pos++;
      if (pos <= DB) rd[pos-1] = bus.Q;
      else if (pos == DB + 1) rpar = bus.Q;
      else begin
        rx_q.push_back({((^rd ^ rpar) != 1'b1) || (bus.Q != 1'b0), rd});
        pos = -1;
      end
    end
  end
  task automatic send(input logic [DB-1:0] w);
    int n;
    n = 0;
    bus.Valid = 1'b1;
    bus.Din = w;
    while (!bus.Ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!bus.Ready) begin
      bad++;
      $display("FAIL send_timeout: Ready=%b want 1", bus.Ready);
    end
    @(negedge clk);
    bus.Valid = 1'b0;
    exp_q.push_back(w);
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.Busy || !bus.Ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.Busy || !bus.Ready) begin
      bad++;
      $display("FAIL idle_timeout: Busy=%b Ready=%b want 0 1", bus.Busy, bus.Ready);
    end
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    bus.Valid = 1'b1;
    bus.Din = 5'h1F;
    repeat (3) @(negedge clk);
    total += 3;
    if (bus.Q !== 1'b1) begin bad++; $display("FAIL reset_q: got %b want 1", bus.Q); end
    if (bus.Busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
    if (bus.Ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.Ready); end
    bus.Valid = 1'b0;
    rst_n = 1'b1;
  endtask
  task automatic test_idle_hold();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      total++;
      if (bus.Q !== 1'b1 || bus.Busy !== 1'b0 || bus.Ready !== 1'b1) begin
        bad++;
        $display("FAIL idle_hold cyc %0d: Q=%b Busy=%b Ready=%b want 1 0 1", i, bus.Q, bus.Busy, bus.Ready);
      end
    end
  endtask
  task automatic test_single();
    logic [FL-1:0] got;
    logic [DB:0] r;
    int busy_cnt;
    busy_cnt = 0;
    send(5'b10110);
    total++;
    if (bus.Ready !== 1'b0) begin bad++; $display("FAIL single_ready_low: got %b want 0", bus.Ready); end
    for (int i = 1; i <= FL + 2; i++) begin
      @(negedge clk);
      if (bus.Busy === 1'b1) busy_cnt++;
      if (i == 1) begin
        total++;
        if (bus.Ready !== 1'b1) begin bad++; $display("FAIL single_ready_back: got %b want 1", bus.Ready); end
      end
      if (i >= 2 && i <= FL + 1) got[i-2] = bus.Q;
    end
    total += 3;
    if (got !== frame(5'b10110)) begin bad++; $display("FAIL single_slots: got %b want %b", got, frame(5'b10110)); end
    if (bus.Q !== 1'b1) begin bad++; $display("FAIL single_after: got %b want 1", bus.Q); end
    if (busy_cnt != FL) begin bad++; $display("FAIL single_busy_len: got %0d want %0d", busy_cnt, FL); end
    total++;
    if (rx_q.size() == 0 || exp_q.size() == 0) begin
      bad++;
      $display("FAIL single_rx: got %0d frames want 1", rx_q.size());
    end else begin
      r = rx_q.pop_front();
      if (r !== {1'b0, exp_q[0]}) begin bad++; $display("FAIL single_rx: got %h want %h", r, {1'b0, exp_q[0]}); end
      void'(exp_q.pop_front());
    end
  endtask
  task automatic test_parity();
    logic [DB-1:0] words [2];
    logic pars [2];
    logic [FL-1:0] got;
    words[0] = 5'b00000; pars[0] = 1'b1;
    words[1] = 5'b11111; pars[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      send(words[k]);
      @(negedge clk);
      for (int s = 0; s < FL; s++) begin
        @(negedge clk);
        got[s] = bus.Q;
      end
      total += 2;
      if (got[FL-2] !== pars[k]) begin bad++; $display("FAIL parity_%0d: got %b want %b", k, got[FL-2], pars[k]); end
      if (got !== frame(words[k])) begin bad++; $display("FAIL parity_frame_%0d: got %b want %b", k, got, frame(words[k])); end
      @(negedge clk);
      total++;
      if (rx_q.size() == 0 || exp_q.size() == 0 || rx_q[0] !== {1'b0, exp_q[0]}) begin
        bad++;
        $display("FAIL parity_rx_%0d: got %0d frames want 1 matching %h", k, rx_q.size(), words[k]);
      end
      rx_q.delete();
      exp_q.delete();
    end
  endtask
  task automatic test_back_to_back();
    logic [2*FL-1:0] got;
    logic [2*FL-1:0] want;
    logic r;
    int acc;
    acc = 0;
    want = {frame(5'h0A), frame(5'h15)};
    send(5'h15);
    total++;
    if (bus.Ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_low: got %b want 0", bus.Ready); end
    bus.Valid = 1'b1;
    bus.Din = 5'h0A;
    for (int i = 1; i <= 2 * FL + 1; i++) begin
      r = bus.Ready;
      @(negedge clk);
      if (bus.Valid && r) begin
        bus.Valid = 1'b0;
        acc = i;
        exp_q.push_back(5'h0A);
      end
      if (i >= 2) got[i-2] = bus.Q;
    end
    total += 2;
    if (acc != 2) begin bad++; $display("FAIL b2b_accept_cycle: got %0d want 2", acc); end
    if (got !== want) begin bad++; $display("FAIL b2b_slots: got %b want %b", got, want); end
    wait_idle();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (rx_q.size() == 0 || exp_q.size() == 0) begin
        bad++;
        $display("FAIL b2b_rx_%0d: got %0d frames want 2", k, rx_q.size() + k);
      end else if (rx_q.pop_front() !== {1'b0, exp_q.pop_front()}) begin
        bad++;
        $display("FAIL b2b_rx_%0d: decoded word differs from sent word", k);
      end
    end
    rx_q.delete();
    exp_q.delete();
  endtask
  task automatic test_mid_reset();
    logic [FL-1:0] fa;
    logic r;
    int leak;
    leak = 0;
    fa = frame(5'h09);
    send(5'h09);
    bus.Valid = 1'b1;
    bus.Din = 5'h12;
    for (int i = 1; i <= 5; i++) begin
      r = bus.Ready;
      @(negedge clk);
      if (bus.Valid && r) bus.Valid = 1'b0;
    end
    exp_q.delete();
    total++;
    if (bus.Q !== fa[3] || bus.Busy !== 1'b1 || bus.Ready !== 1'b0) begin
      bad++;
      $display("FAIL midrst_pre: Q=%b Busy=%b Ready=%b want %b 1 0", bus.Q, bus.Busy, bus.Ready, fa[3]);
    end
    rst_n = 1'b0;
    bus.Valid = 1'b1;
    bus.Din = 5'h1F;
    @(negedge clk);
    total++;
    if (bus.Q !== 1'b1 || bus.Busy !== 1'b0 || bus.Ready !== 1'b1) begin
      bad++;
      $display("FAIL midrst_post: Q=%b Busy=%b Ready=%b want 1 0 1", bus.Q, bus.Busy, bus.Ready);
    end
    rst_n = 1'b1;
    bus.Valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.Q !== 1'b1 || bus.Busy !== 1'b0) leak++;
    end
    total += 2;
    if (leak != 0) begin bad++; $display("FAIL midrst_quiet: got %0d active cycles want 0", leak); end
    if (rx_q.size() != 0) begin bad++; $display("FAIL midrst_rx: got %0d frames want 0", rx_q.size()); end
    rx_q.delete();
  endtask
  task automatic test_loopback();
    logic [DB:0] r;
    logic [DB-1:0] w;
    for (int k = 0; k < 32; k++) send(DB'($urandom_range(0, 31)));
    wait_idle();
    total++;
    if (rx_q.size() != 32) begin bad++; $display("FAIL loop_count: got %0d want 32", rx_q.size()); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front();
      w = exp_q.pop_front();
      total++;
      if (r !== {1'b0, w}) begin bad++; $display("FAIL loop_word: got err=%b data=%h want err=0 data=%h", r[DB], r[DB-1:0], w); end
    end
  endtask
  initial begin
    bus.Valid = 1'b0;
    bus.Din = '0;
    test_reset();
    test_idle_hold();
    test_single();
    test_parity();
    test_back_to_back();
    test_mid_reset();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
